// File: rtl/cva6_su_drain_model.sv
// Drain stage for the store-unit model: counts committed stores and retires them in order over req/gnt.
// Optional grant-timeout watchdog compiled in when SU_DRAIN_WATCHDOG_EN is defined.
module cva6_su_drain_model #(
  parameter int unsigned MAX_PENDING = 4,
  parameter int unsigned MEM_LAT     = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               commit_i,
  input  logic                               mem_gnt_i,
  output logic                               mem_req_o,
  output logic                               store_mem_resp_o,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending_o,
  output logic                               busy_o,
  output logic                               err_o,
  output logic                               watchdog_o
);

  // state | meaning
  // IDLE  | nothing in flight; start a request once a committed store is pending
  // REQ   | request for the oldest store held until granted
  // WAIT  | granted; counting down the memory latency
  // RESP  | one-cycle retire pulse, credit returned
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  localparam int unsigned CntW = $clog2(MAX_PENDING + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_PENDING);
  localparam logic [3:0] LatInit = 4'(MEM_LAT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      lat_q;
  logic            mem_req_q, resp_q, busy_q, err_q;
  logic            inc, dec;

  assign inc = commit_i;
  assign dec = (state_q == RESP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cnt_q != '0) state_d = REQ;
      REQ:     if (mem_gnt_i) state_d = WAIT;
      WAIT:    if (lat_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are pure flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lat_q     <= 4'd0;
      mem_req_q <= 1'b0;
      resp_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= (state_d == REQ);
      resp_q    <= (state_d == RESP);
      busy_q    <= (state_d != IDLE);

      if (state_q == REQ && mem_gnt_i) begin
        lat_q <= LatInit;
      end else if (state_q == WAIT && lat_q != 4'd0) begin
        lat_q <= lat_q - 4'd1;
      end

      // RESP is only reached with cnt >= 1, so the decrement cannot underflow.
      if (inc && !dec) begin
        if (cnt_q == CntMax) begin
          err_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end else if (dec && !inc) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

  assign mem_req_o        = mem_req_q;
  assign store_mem_resp_o = resp_q;
  assign busy_o           = busy_q;
  assign err_o            = err_q;
  assign pending_o        = cnt_q;

`ifdef SU_DRAIN_WATCHDOG_EN
  logic [4:0] wd_cnt_q;
  logic       wd_q;

  // Flag raised on the edge where the ungranted-request count reaches 16.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_q <= 5'd0;
      wd_q     <= 1'b0;
    end else if (state_q == REQ && !mem_gnt_i) begin
      if (wd_cnt_q != 5'd16) wd_cnt_q <= wd_cnt_q + 5'd1;
      if (wd_cnt_q == 5'd15) wd_q <= 1'b1;
    end else begin
      wd_cnt_q <= 5'd0;
    end
  end

  assign watchdog_o = wd_q;
`else
  assign watchdog_o = 1'b0;
`endif

endmodule

// File: tb/tb_cva6_su_drain_model.sv
// Bench for cva6_su_drain_model: directed scenarios plus random commit/grant traffic against a
// timestamp-based reference model of the drain pipeline.
module tb_cva6_su_drain_model;
  localparam int MAX_PENDING = 4;
  localparam int MEM_LAT     = 2;
  localparam int CW          = $clog2(MAX_PENDING + 1);
`ifdef SU_DRAIN_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk_i = 1'b0, rst_ni = 1'b0, commit_i = 1'b0, mem_gnt_i = 1'b0;
  logic mem_req_o, store_mem_resp_o, busy_o, err_o, watchdog_o;
  logic [CW-1:0] pending_o;

  int checks = 0, failures = 0;

  // Reference model: time-stamped view of the single in-flight store.
  int m_cyc = 0;     // index of the current cycle
  int m_due = -1;    // cycle in which the in-flight store's response appears
  int m_cnt = 0;
  int m_ng  = 0;     // consecutive ungranted request cycles
  bit m_req = 0, m_err = 0, m_wd = 0;

  int n_resp = 0, last_resp = -1, max_pend = 0, gap_bad = 0;

  always #5 clk_i = ~clk_i;

  cva6_su_drain_model #(.MAX_PENDING(MAX_PENDING), .MEM_LAT(MEM_LAT)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .commit_i         (commit_i),
    .mem_gnt_i        (mem_gnt_i),
    .mem_req_o        (mem_req_o),
    .store_mem_resp_o (store_mem_resp_o),
    .pending_o        (pending_o),
    .busy_o           (busy_o),
    .err_o            (err_o),
    .watchdog_o       (watchdog_o)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_due = -1; m_req = 0; m_cnt = 0; m_ng = 0; m_err = 0; m_wd = 0;
  endtask

  // Advance the model across one clock edge using the inputs of the cycle just ending.
  task automatic model_step(input bit c, input bit g);
    bit resp_now, idle_now;
    int cnt_old;
    resp_now = (m_due == m_cyc);
    idle_now = !m_req && (m_due < m_cyc);
    cnt_old  = m_cnt;
    if (m_req) begin
      if (g) begin
        m_req = 0;
        m_due = m_cyc + MEM_LAT + 1;
        m_ng  = 0;
      end else begin
        m_ng++;
        if (WD_EN && m_ng >= 16) m_wd = 1;
      end
    end else if (idle_now && cnt_old != 0) begin
      m_req = 1;
      m_ng  = 0;
    end
    if (c && !resp_now) begin
      if (m_cnt == MAX_PENDING) m_err = 1;
      else m_cnt++;
    end else if (!c && resp_now) begin
      m_cnt--;
    end
    m_cyc++;
  endtask

  task automatic check_all(input string tag);
    bit e_resp, e_busy;
    e_resp = (m_due == m_cyc);
    e_busy = m_req || (m_due >= m_cyc);
    chk($sformatf("%s.req", tag),  8'(mem_req_o), 8'(m_req));
    chk($sformatf("%s.resp", tag), 8'(store_mem_resp_o), 8'(e_resp));
    chk($sformatf("%s.pend", tag), 8'(pending_o), 8'(m_cnt));
    chk($sformatf("%s.busy", tag), 8'(busy_o), 8'(e_busy));
    chk($sformatf("%s.err", tag),  8'(err_o), 8'(m_err));
    chk($sformatf("%s.wd", tag),   8'(watchdog_o), 8'(m_wd));
    if (store_mem_resp_o === 1'b1) begin
      n_resp++;
      if (last_resp >= 0 && (m_cyc - last_resp) != MEM_LAT + 3) gap_bad++;
      last_resp = m_cyc;
    end
    if (int'(pending_o) > max_pend) max_pend = int'(pending_o);
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic cycle(input bit c, input bit g, input string tag);
    commit_i  = c;
    mem_gnt_i = g;
    @(posedge clk_i);
    model_step(c, g);
    @(negedge clk_i);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; commit_i = 1'b0; mem_gnt_i = 1'b0;
    #1;
    model_reset();
    check_all("rst_now");
    @(negedge clk_i);
    check_all("rst_hold");
    rst_ni = 1'b1;
  endtask

  task automatic clear_stats();
    n_resp = 0; last_resp = -1; max_pend = 0; gap_bad = 0;
  endtask

  initial begin
    @(negedge clk_i);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, "idle");

    // Single store, grant tied high: req only after E1, resp only after E4.
    cycle(1, 1, "one_c");
    for (int k = 1; k <= 6; k++) begin
      cycle(0, 1, "one");
      chk($sformatf("one_req_k%0d", k), 8'(mem_req_o), 8'(k == 1));
      chk($sformatf("one_resp_k%0d", k), 8'(store_mem_resp_o), 8'(k == 4));
    end
    chk("one_pend_end", 8'(pending_o), 8'd0);

    // Four back-to-back commits.
    clear_stats();
    for (int i = 0; i < 4; i++) cycle(1, 1, "four_c");
    for (int i = 0; i < 25; i++) cycle(0, 1, "four");
    chk("four_nresp", 8'(n_resp), 8'd4);
    chk("four_peak", 8'(max_pend), 8'd4);
    chk("four_gap", 8'(gap_bad), 8'd0);
    chk("four_err", 8'(err_o), 8'd0);

    // Overflow with grant held low.
    clear_stats();
    for (int i = 0; i < 5; i++) cycle(1, 0, "ovf_c");
    chk("ovf_pend", 8'(pending_o), 8'd4);
    chk("ovf_err", 8'(err_o), 8'd1);
    for (int i = 0; i < 30; i++) cycle(0, 1, "ovf_drain");
    chk("ovf_nresp", 8'(n_resp), 8'd4);
    chk("ovf_err_sticky", 8'(err_o), 8'd1);

    // Grant starvation.
    do_reset();
    cycle(1, 0, "wd_c");
    for (int i = 0; i < 20; i++) cycle(0, 0, "wd");
    chk("wd_final", 8'(watchdog_o), 8'(WD_EN));
    for (int i = 0; i < 8; i++) cycle(0, 1, "wd_drain");

    // Reset while the store is in WAIT drops it.
    do_reset();
    clear_stats();
    cycle(1, 1, "rw_c");
    cycle(0, 1, "rw_req");
    cycle(0, 1, "rw_wait");
    chk("rw_in_wait_busy", 8'(busy_o), 8'd1);
    do_reset();
    chk("rw_pend_zero", 8'(pending_o), 8'd0);
    for (int i = 0; i < 6; i++) cycle(0, 1, "rw_after");
    chk("rw_no_resp", 8'(n_resp), 8'd0);
    cycle(1, 1, "rw_new_c");
    for (int i = 0; i < 6; i++) cycle(0, 1, "rw_new");
    chk("rw_new_resp", 8'(n_resp), 8'd1);

    // Random commit/grant traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), "rnd");
    end
    for (int i = 0; i < 40; i++) cycle(0, 1, "rnd_drain");
    chk("rnd_pend_end", 8'(pending_o), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cva6_su_drain_model.md
# cva6_su_drain_model

Behavioural drain stage for the CVA6 store-unit verification model. It sits directly downstream of the store-unit queue model. It counts committed stores (one `commit_i` pulse per store) and issues one memory request per committed store over a req/gnt handshake. After a fixed memory latency it pulses `store_mem_resp_o` to retire that store from the queue. Stores drain strictly in commit order, one in flight at a time.

## Interface
- `MAX_PENDING`, 4: maximum committed-but-undrained stores; matches store queue depth.
- `MEM_LAT`, 2: cycles from grant to response; legal range 1..15.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low; clock `clk_i`.
- `commit_i`  in  1  one store committed this cycle.
- `mem_gnt_i`  in  1  memory accepts the current request; sampled only while `mem_req_o`=1.
- `mem_req_o`  out  1  request for the oldest committed store.
- `store_mem_resp_o`  out  1  one-cycle pulse: oldest committed store written; feeds the store queue's `store_mem_resp_i`.
- `pending_o`  out  $clog2(MAX_PENDING+1)  committed stores not yet responded.
- `busy_o`  out  1  FSM not in IDLE.
- `err_o`  out  1  sticky overflow flag.
- `watchdog_o`  out  1  sticky grant-timeout flag; only driven when the watchdog is compiled in.

## Operation
- Credit counter `cnt`:
  - +1 on `commit_i`; −1 in the RESP cycle. Both in the same cycle leaves it unchanged.
  - `commit_i` while `cnt`==MAX_PENDING with no decrement: `cnt` saturates and `err_o` sets. Only reset clears `err_o`.
  - Decrement with `cnt`==0 cannot occur, because RESP is entered only with `cnt`≥1.
- FSM states: IDLE, REQ, WAIT, RESP. All outputs are Moore, decoded from registered state.
  - IDLE: if `cnt`≠0 → REQ.
  - REQ: `mem_req_o`=1. On `mem_gnt_i`: load `lat_q`←MEM_LAT−1 and go → WAIT. Otherwise stay; the request is held until granted.
  - WAIT: if `lat_q`==0 → RESP, else `lat_q`−1.
  - RESP: `store_mem_resp_o`=1 for exactly one cycle, `cnt` decrements, → IDLE.
- `busy_o` = (state≠IDLE). `pending_o` = `cnt`.
- Arithmetic:
  - `lat_q` is 4 bits.
  - `cnt` is unsigned, width $clog2(MAX_PENDING+1). It never wraps; it saturates at MAX_PENDING.
- Reset, including mid-operation:
  - Clears state to IDLE, `cnt`, `lat_q`, `err_o` and `watchdog_o`.
  - All outputs read 0 during and after reset.
  - An in-flight store is dropped and no response is emitted for it.

## Timing
- Commit at edge E0 with `mem_gnt_i` tied to 1: `mem_req_o` is high in the cycle after E1, and `store_mem_resp_o` is high in the cycle after E(MEM_LAT+2).
- Grant delayed by d cycles adds d cycles to the response.
- Back-to-back stores: RESP→IDLE→REQ costs 2 cycles. Issue interval with gnt tied high is MEM_LAT+3 cycles.
- `commit_i` in the same cycle as RESP is counted. Net `cnt` is unchanged and the FSM re-requests from IDLE.
- `mem_gnt_i` is ignored in IDLE, WAIT and RESP.

## Configuration
- `SU_DRAIN_WATCHDOG_EN` defined:
  - A 5-bit counter runs while in REQ without grant. It clears on grant or on leaving REQ.
  - At count 16, `watchdog_o` sets (sticky until reset).
  - FSM behaviour is unchanged.
- Not defined: no counter is instantiated and `watchdog_o` is tied 0.

## Test plan
- Reset, then 3 idle cycles with `commit_i`=0 → all outputs 0 and `busy_o`=0.
- One `commit_i` pulse at E0, gnt tied 1, MEM_LAT=2 → `mem_req_o` high for 1 cycle after E1; `store_mem_resp_o` high only in the cycle after E4; `pending_o` goes 1→0.
- Four commits on consecutive cycles, gnt tied 1 → `pending_o` peaks at 4; exactly 4 resp pulses spaced 5 cycles apart; `pending_o` returns to 0; `err_o` stays 0.
- Five commits with gnt held 0 → `pending_o`=4 and `err_o`=1. Then release gnt → exactly 4 responses.
- Gnt held 0 for 20 cycles while requesting:
  - With `SU_DRAIN_WATCHDOG_EN` → `watchdog_o` rises 16 cycles after `mem_req_o` first goes high.
  - Without the macro → `watchdog_o` stays 0.
- `rst_ni` asserted while in WAIT → `store_mem_resp_o` never pulses; `pending_o`=0 immediately. A new commit after reset drains normally.
